// File: rtl/countdown_pkg.sv
// Shared types and constants for the programmable countdown timer.
// Optional sticky interrupt is enabled with COUNTDOWN_TIMER_IRQ_EN.
package countdown_pkg;

   localparam int COUNTDOWN_MIN_WIDTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } timer_state_t;

endpackage

// File: rtl/countdown_dp.sv
// Countdown datapath: count, reload and mode registers plus the count==1 flag.
// Control priority is clear > load > reload > decrement.
module countdown_dp
   import countdown_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic             reload,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_val,
   input  logic             periodic,
   output logic [WIDTH-1:0] count,
   output logic             mode,
   output logic             is_one
);

   logic [WIDTH-1:0] reload_val;

   // Decrement refuses to move past zero so the count can never wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         reload_val <= '0;
         mode       <= 1'b0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count      <= load_val;
         reload_val <= load_val;
         mode       <= periodic;
      end else if (reload) begin
         count <= reload_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Programmable countdown timer: one-shot or periodic, gated by tick, Mealy trigger.
// Define COUNTDOWN_TIMER_IRQ_EN to add the sticky irq output and irq_clr input.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             tick,
   input  logic             periodic,
   input  logic [WIDTH-1:0] load_val,
`ifdef COUNTDOWN_TIMER_IRQ_EN
   input  logic             irq_clr,
   output logic             irq,
`endif
   output logic             trigger,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   timer_state_t state, next_state;
   logic trig_raw;
   logic load, dec, reload, clear;
   logic mode, is_one;

   countdown_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .dec      (dec),
      .reload   (reload),
      .clear    (clear),
      .load_val (load_val),
      .periodic (periodic),
      .count    (count),
      .mode     (mode),
      .is_one   (is_one)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // stop beats start beats tick; a restart swallows any pending expiry.
   always_comb begin
      next_state = state;
      trig_raw   = 1'b0;
      load       = 1'b0;
      dec        = 1'b0;
      reload     = 1'b0;
      clear      = 1'b0;
      if (stop) begin
         clear      = 1'b1;
         next_state = ST_IDLE;
      end else if (start) begin
         if (load_val != '0) begin
            load       = 1'b1;
            next_state = ST_RUN;
         end else begin
            clear      = 1'b1;
            trig_raw   = 1'b1;
            next_state = ST_DONE;
         end
      end else if ((state == ST_RUN) && tick) begin
         if (is_one) begin
            trig_raw = 1'b1;
            if (mode) begin
               reload = 1'b1;
            end else begin
               clear      = 1'b1;
               next_state = ST_DONE;
            end
         end else begin
            dec = 1'b1;
         end
      end
   end

   // Gating with rst_n keeps the combinational strobe quiet during reset.
   assign trigger = trig_raw & rst_n;
   assign busy    = (state == ST_RUN);
   assign done    = (state == ST_DONE);

`ifdef COUNTDOWN_TIMER_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       irq <= 1'b0;
      else if (trigger) irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
   end
`endif

endmodule
